alu16_reg: RTL and testbench

- 16-bit registered ALU for the multicycle CPU datapath.
- Performs add, subtract, bitwise AND, bitwise OR, one's complement and pass-through on operands x and y, selected by a 3-bit function code.
- Result and two adder carry flags are captured in output registers on the rising clock edge.
- Feeds the CPU's result bus and overflow/carry logic: overflow = c_n XOR c_n_minus_1.

---
 rtl/alu16_reg.sv | 61 ++++++
 tb/tb_alu16_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu16_reg.sv
// Registered 16-bit ALU: add/sub/and/or/not/pass with adder carry flags.
// Flags always report the adder carries out of the top two bit positions.
module alu16_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       fnsel,
    output logic [WIDTH-1:0] z,
    output logic             c_n,
    output logic             c_n_minus_1
);

    logic             cin;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] lo;
    logic [1:0]       hi;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;

    // Split the adder so the carry into the top bit is directly visible.
    always_comb begin
        cin = fnsel[0];
        y1  = y ^ {WIDTH{cin}};
        lo  = {1'b0, x[WIDTH-2:0]}
            + {1'b0, y1[WIDTH-2:0]}
            + {{(WIDTH-1){1'b0}}, cin};
        hi  = {1'b0, x[WIDTH-1]}
            + {1'b0, y1[WIDTH-1]}
            + {1'b0, lo[WIDTH-1]};
        sum = {hi[0], lo[WIDTH-2:0]};
    end

    always_comb begin
        res = '0;
        unique case (fnsel)
            3'd0:    res = sum;
            3'd1:    res = sum;
            3'd2:    res = x & y;
            3'd3:    res = x | y;
            3'd5:    res = ~x;
            3'd6:    res = x;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z           <= '0;
            c_n         <= 1'b0;
            c_n_minus_1 <= 1'b0;
        end else begin
            z           <= res;
            c_n         <= hi[1];
            c_n_minus_1 <= lo[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu16_reg.sv
// Scoreboard bench for alu16_reg: expected results queued at drive time,
// popped and compared one cycle later when the registered outputs update.
module tb_alu16_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  fnsel;
    logic [15:0] z;
    logic        c_n;
    logic        c_n_minus_1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        r;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  f;
        logic [15:0] ez;
        logic        ec;
        logic        ecm;
    } vec_t;

    logic [17:0] sb[$];
    logic [17:0] exp_v;

    alu16_reg dut (
        .clk(clk),
        .rst(rst),
        .x(x),
        .y(y),
        .fnsel(fnsel),
        .z(z),
        .c_n(c_n),
        .c_n_minus_1(c_n_minus_1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [15:0] a,
                                input logic [15:0] b, input logic [2:0] f,
                                input logic [15:0] ez, input logic ec,
                                input logic ecm);
        mk = '{r: r, a: a, b: b, f: f, ez: ez, ec: ec, ecm: ecm};
    endfunction

    // Reference model: carry into the msb recovered from the msb sum bit.
    function automatic vec_t model(input logic r, input logic [15:0] a,
                                   input logic [15:0] b, input logic [2:0] f);
        logic [15:0] bm;
        logic [16:0] s;
        logic [15:0] rz;
        logic        c14;
        bm  = f[0] ? ~b : b;
        s   = {1'b0, a} + {1'b0, bm} + {16'd0, f[0]};
        c14 = s[15] ^ a[15] ^ bm[15];
        case (f)
            3'd0, 3'd1: rz = s[15:0];
            3'd2:       rz = a & b;
            3'd3:       rz = a | b;
            3'd5:       rz = ~a;
            3'd6:       rz = a;
            default:    rz = 16'h0000;
        endcase
        if (r) model = mk(r, a, b, f, 16'h0000, 1'b0, 1'b0);
        else   model = mk(r, a, b, f, rz, s[16], c14);
    endfunction

    task automatic drive(input vec_t v);
        rst   = v.r;
        x     = v.a;
        y     = v.b;
        fnsel = v.f;
        sb.push_back({v.ez, v.ec, v.ecm});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t t[$];
        t = '{mk(1, 16'd5, 16'd12, 3'd0, 16'h0000, 0, 0),
              mk(1, 16'd5, 16'd12, 3'd0, 16'h0000, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd0, 16'h0011, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            exp_v = sb.pop_front();
            checks++;
            if ({z, c_n, c_n_minus_1} !== exp_v) begin
                errors++;
                $display("FAIL reset[%0d]: got z=%h c=%b%b, want z=%h c=%b%b",
                         i, z, c_n, c_n_minus_1, exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_arith_logic();
        vec_t t[$];
        t = '{mk(0, 16'd5, 16'd12, 3'd0, 16'h0011, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd1, 16'hFFF9, 0, 0),
              mk(0, 16'h1234, 16'h1234, 3'd1, 16'h0000, 1, 1),
              mk(0, 16'd5, 16'd12, 3'd2, 16'h0004, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd3, 16'h000D, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd5, 16'hFFFA, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd6, 16'h0005, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd4, 16'h0000, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd7, 16'h0000, 0, 0),
              mk(0, 16'h1234, 16'h1234, 3'd4, 16'h0000, 0, 0),
              mk(0, 16'h1234, 16'h1234, 3'd5, 16'hEDCB, 1, 1),
              mk(0, 16'hF0F0, 16'h0FF0, 3'd3, 16'hFFF0, 1, 1)};
        foreach (t[i]) begin
            drive(t[i]);
            exp_v = sb.pop_front();
            checks++;
            if ({z, c_n, c_n_minus_1} !== exp_v) begin
                errors++;
                $display("FAIL op[%0d] f=%0d: got z=%h c=%b%b, want z=%h c=%b%b",
                         i, t[i].f, z, c_n, c_n_minus_1,
                         exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t t[$];
        t = '{mk(0, 16'h7FFF, 16'h0001, 3'd0, 16'h8000, 0, 1),
              mk(0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1, 1),
              mk(0, 16'h8000, 16'h8000, 3'd0, 16'h0000, 1, 0),
              mk(0, 16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            exp_v = sb.pop_front();
            checks++;
            if ({z, c_n, c_n_minus_1} !== exp_v) begin
                errors++;
                $display("FAIL ovf[%0d]: got z=%h c=%b%b, want z=%h c=%b%b",
                         i, z, c_n, c_n_minus_1, exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t t[$];
        t = '{mk(0, 16'd5, 16'd12, 3'd0, 16'h0011, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd2, 16'h0004, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd1, 16'hFFF9, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd3, 16'h000D, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd0, 16'h0011, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd5, 16'hFFFA, 0, 0),
              mk(0, 16'd5, 16'd12, 3'd4, 16'h0000, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            exp_v = sb.pop_front();
            checks++;
            if ({z, c_n, c_n_minus_1} !== exp_v) begin
                errors++;
                $display("FAIL b2b[%0d]: got z=%h c=%b%b, want z=%h c=%b%b",
                         i, z, c_n, c_n_minus_1, exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t t[$];
        t = '{mk(0, 16'hABCD, 16'h0000, 3'd6, 16'hABCD, 0, 0),
              mk(1, 16'hABCD, 16'h0000, 3'd6, 16'h0000, 0, 0),
              mk(0, 16'hABCD, 16'h0000, 3'd6, 16'hABCD, 0, 0),
              mk(0, 16'hABCD, 16'h0000, 3'd6, 16'hABCD, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            exp_v = sb.pop_front();
            checks++;
            if ({z, c_n, c_n_minus_1} !== exp_v) begin
                errors++;
                $display("FAIL rst_mid[%0d]: got z=%h c=%b%b, want z=%h c=%b%b",
                         i, z, c_n, c_n_minus_1, exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_random();
        vec_t v;
        for (int i = 0; i < 200; i++) begin
            v = model($urandom_range(0, 15) == 0,
                      16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
            drive(v);
            exp_v = sb.pop_front();
            checks++;
            if ({z, c_n, c_n_minus_1} !== exp_v) begin
                errors++;
                $display("FAIL rand[%0d] r=%b x=%h y=%h f=%0d: got z=%h c=%b%b, want z=%h c=%b%b",
                         i, v.r, v.a, v.b, v.f, z, c_n, c_n_minus_1,
                         exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        x     = '0;
        y     = '0;
        fnsel = '0;
        #2;
        test_reset();
        test_arith_logic();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
